// File: rtl/msf_frame_decoder_if.sv
// Bundles the sampling inputs and decoded-time outputs of the MSF frame decoder.
// The master side drives sample/carrier; the slave side is the decoder itself.
interface msf_frame_decoder_if;
    logic       sample_i;
    logic       carrier_i;
    logic       sec_tick_o;
    logic       load_o;
    logic [1:0] hour_h_o;
    logic [3:0] hour_l_o;
    logic [2:0] minute_h_o;
    logic [3:0] minute_l_o;
    logic [2:0] second_h_o;
    logic [3:0] second_l_o;
    logic       synced_o;
    logic       error_o;

    modport master (
        output sample_i, carrier_i,
        input  sec_tick_o, load_o, hour_h_o, hour_l_o, minute_h_o, minute_l_o,
               second_h_o, second_l_o, synced_o, error_o
    );

    modport slave (
        input  sample_i, carrier_i,
        output sec_tick_o, load_o, hour_h_o, hour_l_o, minute_h_o, minute_l_o,
               second_h_o, second_l_o, synced_o, error_o
    );
endinterface

// File: rtl/msf_frame_decoder.sv
// MSF 60 kHz time-code decoder: measures 1 s frames, collects A39..A59 and B57,
// validates the minute and loads HH:MM:00 at the following second-0 edge.
module msf_frame_decoder #(
    parameter int TICKS_PER_100MS = 10
) (
    input  logic               clk_i,
    input  logic               rst_i,
    msf_frame_decoder_if.slave bus
);
    localparam int T  = TICKS_PER_100MS;
    localparam int CW = $clog2(11 * T + 1);
    localparam logic [CW-1:0] E_GLITCH = CW'(T / 2);
    localparam logic [CW-1:0] E_A      = CW'((3 * T) / 2);
    localparam logic [CW-1:0] E_B      = CW'((5 * T) / 2);
    localparam logic [CW-1:0] E_WIN    = CW'(9 * T);
    localparam logic [CW-1:0] E_TO     = CW'(11 * T);

    typedef enum logic [1:0] {HUNT, MEASURE, WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] elapsed_q, elapsed_d;
    logic [20:0]   a_sr_q, a_sr_d;
    logic [2:0]    b_sr_q, b_sr_d;
    logic [4:0]    bitcnt_q, bitcnt_d;
    logic          armed_q, armed_d;
    logic          acc_q, acc_d;
    logic          prev_q, prev_d;
    logic          a_bit_q, a_bit_d;
    logic [1:0]    st_hh_q, st_hh_d, hour_h_q, hour_h_d;
    logic [3:0]    st_hl_q, st_hl_d, hour_l_q, hour_l_d;
    logic [2:0]    st_mh_q, st_mh_d, minute_h_q, minute_h_d;
    logic [3:0]    st_ml_q, st_ml_d, minute_l_q, minute_l_d;
    logic          synced_q, synced_d;
    logic          load_q, load_d, tick_q, tick_d, err_q, err_d;

    // Candidate window after shifting in the frame being classified right now.
    logic        fall;
    logic [20:0] a_shift;
    logic [2:0]  b_shift;
    logic [4:0]  cnt_inc;
    logic [1:0]  f_hh;
    logic [3:0]  f_hl, f_ml;
    logic [2:0]  f_mh;
    logic        frame_ok;

    always_comb begin
        fall     = prev_q & ~bus.carrier_i;
        a_shift  = {a_sr_q[19:0], a_bit_q};
        b_shift  = {b_sr_q[1:0], ~bus.carrier_i};
        cnt_inc  = (bitcnt_q == 5'd21) ? 5'd21 : bitcnt_q + 5'd1;
        f_hh     = a_shift[20:19];
        f_hl     = a_shift[18:15];
        f_mh     = a_shift[14:12];
        f_ml     = a_shift[11:8];
        frame_ok = (cnt_inc == 5'd21) && (a_shift[7:0] == 8'b0111_1110)
                && ((^{a_shift[20:8], b_shift[2]}) == 1'b1)
                && (f_hh <= 2'd2) && (f_hl <= 4'd9) && (f_hh != 2'd2 || f_hl <= 4'd3)
                && (f_mh <= 3'd5) && (f_ml <= 4'd9);
    end

    always_comb begin
        state_d    = state_q;
        elapsed_d  = elapsed_q;
        a_sr_d     = a_sr_q;
        b_sr_d     = b_sr_q;
        bitcnt_d   = bitcnt_q;
        armed_d    = armed_q;
        acc_d      = acc_q;
        prev_d     = prev_q;
        a_bit_d    = a_bit_q;
        st_hh_d    = st_hh_q;
        st_hl_d    = st_hl_q;
        st_mh_d    = st_mh_q;
        st_ml_d    = st_ml_q;
        hour_h_d   = hour_h_q;
        hour_l_d   = hour_l_q;
        minute_h_d = minute_h_q;
        minute_l_d = minute_l_q;
        synced_d   = synced_q;
        load_d     = 1'b0;
        tick_d     = 1'b0;
        err_d      = 1'b0;
        if (bus.sample_i) begin
            prev_d = bus.carrier_i;
            case (state_q)
                HUNT: begin
                    if (fall) begin
                        state_d   = MEASURE;
                        elapsed_d = CW'(1);
                    end
                end
                MEASURE: begin
                    elapsed_d = elapsed_q + 1'b1;
                    if (elapsed_q == E_GLITCH && bus.carrier_i) begin
                        state_d = acc_q ? WAIT : HUNT;
                    end
                    if (elapsed_q == E_A) begin
                        a_bit_d = ~bus.carrier_i;
                    end
                    if (elapsed_q == E_B) begin
                        a_sr_d   = a_shift;
                        b_sr_d   = b_shift;
                        bitcnt_d = cnt_inc;
                        armed_d  = frame_ok;
                        state_d  = WAIT;
                        if (frame_ok) begin
                            st_hh_d = f_hh;
                            st_hl_d = f_hl;
                            st_mh_d = f_mh;
                            st_ml_d = f_ml;
                        end
                    end
                end
                WAIT: begin
                    elapsed_d = elapsed_q + 1'b1;
                    if (fall && elapsed_q >= E_WIN && elapsed_q < E_TO) begin
                        state_d   = MEASURE;
                        elapsed_d = CW'(1);
                        acc_d     = 1'b1;
                        if (armed_q) begin
                            load_d     = 1'b1;
                            hour_h_d   = st_hh_q;
                            hour_l_d   = st_hl_q;
                            minute_h_d = st_mh_q;
                            minute_l_d = st_ml_q;
                            synced_d   = 1'b1;
                            armed_d    = 1'b0;
                        end else if (synced_q) begin
                            tick_d = 1'b1;
                        end
                    end else if (elapsed_q >= E_TO) begin
                        err_d     = 1'b1;
                        synced_d  = 1'b0;
                        armed_d   = 1'b0;
                        acc_d     = 1'b0;
                        bitcnt_d  = '0;
                        elapsed_d = '0;
                        state_d   = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= HUNT;
            elapsed_q  <= '0;
            a_sr_q     <= '0;
            b_sr_q     <= '0;
            bitcnt_q   <= '0;
            armed_q    <= 1'b0;
            acc_q      <= 1'b0;
            prev_q     <= 1'b1;
            a_bit_q    <= 1'b0;
            st_hh_q    <= '0;
            st_hl_q    <= '0;
            st_mh_q    <= '0;
            st_ml_q    <= '0;
            hour_h_q   <= '0;
            hour_l_q   <= '0;
            minute_h_q <= '0;
            minute_l_q <= '0;
            synced_q   <= 1'b0;
            load_q     <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            elapsed_q  <= elapsed_d;
            a_sr_q     <= a_sr_d;
            b_sr_q     <= b_sr_d;
            bitcnt_q   <= bitcnt_d;
            armed_q    <= armed_d;
            acc_q      <= acc_d;
            prev_q     <= prev_d;
            a_bit_q    <= a_bit_d;
            st_hh_q    <= st_hh_d;
            st_hl_q    <= st_hl_d;
            st_mh_q    <= st_mh_d;
            st_ml_q    <= st_ml_d;
            hour_h_q   <= hour_h_d;
            hour_l_q   <= hour_l_d;
            minute_h_q <= minute_h_d;
            minute_l_q <= minute_l_d;
            synced_q   <= synced_d;
            load_q     <= load_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
        end
    end

    assign bus.sec_tick_o = tick_q;
    assign bus.load_o     = load_q;
    assign bus.hour_h_o   = hour_h_q;
    assign bus.hour_l_o   = hour_l_q;
    assign bus.minute_h_o = minute_h_q;
    assign bus.minute_l_o = minute_l_q;
    assign bus.second_h_o = '0;
    assign bus.second_l_o = '0;
    assign bus.synced_o   = synced_q;
    assign bus.error_o    = err_q;
endmodule

// File: tb/tb_msf_frame_decoder.sv
// Directed bench for msf_frame_decoder: synthesised MSF seconds, one sample_i
// strobe every two clocks, hand-computed expected time fields and pulse counts.
module tb_msf_frame_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cnt_tick = 0, cnt_load = 0, cnt_err = 0, cnt_both = 0;
    logic last_tick, last_load, last_err;
    logic edge_tick, edge_load;

    msf_frame_decoder_if bus_if ();

    msf_frame_decoder #(.TICKS_PER_100MS(10)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_if.sec_tick_o) cnt_tick++;
        if (bus_if.load_o) cnt_load++;
        if (bus_if.error_o) cnt_err++;
        if (bus_if.sec_tick_o && bus_if.load_o) cnt_both++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0d", tag, got);
        end
    endtask

    task automatic send_sample(input logic car);
        @(negedge clk);
        bus_if.carrier_i = car;
        bus_if.sample_i  = 1'b1;
        @(negedge clk);
        bus_if.sample_i  = 1'b0;
        last_tick = bus_if.sec_tick_o;
        last_load = bus_if.load_o;
        last_err  = bus_if.error_o;
    endtask

    // kind 0: normal A/B second; kind 1: second-0 marker (500 ms off).
    task automatic send_second(input logic a, input logic b, input int kind);
        logic off;
        for (int i = 0; i < 100; i++) begin
            if (kind == 1) off = (i < 50);
            else off = (i < 10) || (a && i < 20) || (b && i >= 20 && i < 30);
            send_sample(~off);
            if (i == 0) begin
                edge_tick = last_tick;
                edge_load = last_load;
            end
        end
    endtask

    task automatic send_minute(input int hh, input int mm, input logic flip,
                               input int from_sec, input logic with_zero);
        logic [1:0]  ht;
        logic [3:0]  hu, mu;
        logic [2:0]  mt;
        logic [20:0] a;
        logic        p;
        ht = 2'(hh / 10);
        hu = 4'(hh % 10);
        mt = 3'(mm / 10);
        mu = 4'(mm % 10);
        a  = {ht, hu, mt, mu, 8'b0111_1110};
        p  = (~^a[20:8]) ^ flip;
        for (int s = from_sec; s <= 59; s++) begin
            send_second(a[59 - s], (s == 57) ? p : (s == 41), 0);
        end
        if (with_zero) send_second(1'b1, 1'b1, 1);
    endtask

    initial begin
        int t0, l0, err_idx;
        bus_if.sample_i  = 1'b0;
        bus_if.carrier_i = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_synced", bus_if.synced_o, 0);
        chk("rst_hour_h", bus_if.hour_h_o, 0);
        chk("rst_min_l", bus_if.minute_l_o, 0);
        chk("rst_pulses", cnt_tick + cnt_load + cnt_err, 0);

        // 30 ms glitch in HUNT
        for (int i = 0; i < 100; i++) send_sample(i >= 3);
        chk("glitch_no_tick_load", cnt_tick + cnt_load, 0);

        // Case 1: 23:59 good minute
        send_minute(23, 59, 1'b0, 39, 1'b1);
        chk("t1_load_cnt", cnt_load, 1);
        chk("t1_load_at_edge", edge_load, 1);
        chk("t1_no_tick_at_edge", edge_tick, 0);
        chk("t1_no_tick_unsynced", cnt_tick, 0);
        chk("t1_hour_h", bus_if.hour_h_o, 2);
        chk("t1_hour_l", bus_if.hour_l_o, 3);
        chk("t1_min_h", bus_if.minute_h_o, 5);
        chk("t1_min_l", bus_if.minute_l_o, 9);
        chk("t1_sec", {bus_if.second_h_o, bus_if.second_l_o}, 0);
        chk("t1_synced", bus_if.synced_o, 1);

        // Case 2: five normal seconds, one of them A=0,B=1
        for (int s = 1; s <= 5; s++) begin
            send_second(1'b0, s == 3, 0);
            chk("t2_tick_at_edge", edge_tick, 1);
        end
        chk("t2_tick_cnt", cnt_tick, 5);

        // Case 3: B57 inverted -> tick instead of load
        t0 = cnt_tick; l0 = cnt_load;
        send_minute(23, 59, 1'b1, 39, 1'b1);
        chk("t3_no_load", cnt_load, l0);
        chk("t3_ticks", cnt_tick - t0, 22);
        chk("t3_tick_at_edge", edge_tick, 1);
        chk("t3_synced", bus_if.synced_o, 1);

        // Case 4: hour 25, valid parity
        l0 = cnt_load;
        send_minute(25, 30, 1'b0, 39, 1'b1);
        chk("t4_no_load", cnt_load, l0);
        chk("t4_hour_held", {bus_if.hour_h_o, bus_if.hour_l_o}, 8'h23);

        // Case 5: carrier held high 1.2 s
        err_idx = -1;
        for (int i = 0; i < 120; i++) begin
            send_sample(1'b1);
            if (last_err && err_idx < 0) err_idx = i;
        end
        chk("t5_err_at_110", err_idx, 10);
        chk("t5_err_cnt", cnt_err, 1);
        chk("t5_synced_low", bus_if.synced_o, 0);
        t0 = cnt_tick; l0 = cnt_load;
        send_minute(12, 35, 1'b0, 39, 1'b1);
        chk("t5_no_tick_until_load", cnt_tick, t0);
        chk("t5_reload", cnt_load, l0 + 1);
        chk("t5_time", {bus_if.hour_h_o, bus_if.hour_l_o, bus_if.minute_h_o, bus_if.minute_l_o},
            {2'd1, 4'd2, 3'd3, 4'd5});
        chk("t5_synced", bus_if.synced_o, 1);
        send_second(1'b0, 1'b0, 0);
        chk("t5_tick_resumes", edge_tick, 1);

        // Reset mid-minute, then bitcnt must restart
        send_minute(3, 45, 1'b0, 39, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_synced", bus_if.synced_o, 0);
        chk("rst2_time", {bus_if.hour_h_o, bus_if.hour_l_o, bus_if.minute_h_o, bus_if.minute_l_o}, 0);
        l0 = cnt_load;
        send_minute(3, 45, 1'b0, 45, 1'b1);
        chk("rst2_partial_no_load", cnt_load, l0);
        send_minute(3, 45, 1'b0, 39, 1'b1);
        chk("rst2_full_load", cnt_load, l0 + 1);
        chk("rst2_time_loaded", {bus_if.hour_h_o, bus_if.hour_l_o, bus_if.minute_h_o, bus_if.minute_l_o},
            {2'd0, 4'd3, 3'd4, 4'd5});
        chk("never_load_and_tick", cnt_both, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
